// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debounce array: FSM state encoding,
// counter sizing helper and the default 100 ms stable window at 100 MHz.
package btn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE         = 2'd0;
    localparam state_t PRESS_WAIT   = 2'd1;
    localparam state_t HELD         = 2'd2;
    localparam state_t RELEASE_WAIT = 2'd3;

    localparam int unsigned DEBOUNCE_100MS = 32'd10000000;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, 4-state debounce FSM, registered outputs.
// Optional auto-repeat of the press pulse while held, enabled by `define AUTOREPEAT_EN.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_100MS,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int unsigned     CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          fsm_press;
    logic          rep_fire;
    logic          s;

    assign s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], button};
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        fsm_press = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    level_d   = 1'b1;
                    fsm_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM press only leaves PRESS_WAIT and repeats only fire in HELD/RELEASE_WAIT,
    // so the OR never merges two events and never overlaps a release.
    assign press_d = fsm_press | rep_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned   REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
    localparam int unsigned   RW        = cnt_width(REP_MAX);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rdone_q, rdone_d;

    // rdone selects the period once the first (longer) delay has elapsed.
    always_comb begin
        rcnt_d   = rcnt_q;
        rdone_d  = rdone_q;
        rep_fire = 1'b0;
        if ((state_q == HELD || state_q == RELEASE_WAIT) && state_d != IDLE) begin
            if (rcnt_q == (rdone_q ? REP_NEXT : REP_FIRST)) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                rdone_d  = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end else begin
            rcnt_d  = '0;
            rdone_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q  <= '0;
            rdone_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            rdone_q <= rdone_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire          = 1'b0;
`endif

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_debounce_array.sv
// N_CH independent debounced push-button channels with press/release pulses.
// The release pulse port is named release_pulse ('release' is a reserved word);
// `define AUTOREPEAT_EN adds press auto-repeat while a button is held.
module button_debounce_array
    import btn_pkg::*;
#(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_100MS,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .button        (button[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array with STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5; expectations follow AUTOREPEAT_EN when it is defined.
module tb_button_debounce_array;

    localparam int unsigned N_CH = 5;

    typedef struct packed {
        logic [4:0] btn;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] button;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] release_pulse;

    vec_t tbl [0:127];
    int   n_vec    = 0;
    int   checks   = 0;
    int   failures = 0;

    button_debounce_array #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got lvl/prs/rel=%b_%b_%b want %b_%b_%b", name,
                     got[14:10], got[9:5], got[4:0], exp[14:10], exp[9:5], exp[4:0]);
        end
    endtask

    task automatic step(input logic [4:0] b);
        @(negedge clk);
        button = b;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tbl[n_vec] = '{btn: b, lvl: 5'b0, prs: 5'b0, rel: 5'b0};
            n_vec++;
        end
    endtask

    task automatic mark(input int idx, input logic [4:0] p, input logic [4:0] r);
        tbl[idx].prs = tbl[idx].prs | p;
        tbl[idx].rel = tbl[idx].rel | r;
    endtask

    task automatic lvl_set(input int from, input logic [4:0] m, input logic on);
        for (int i = from; i < n_vec; i++)
            tbl[i].lvl = on ? (tbl[i].lvl | m) : (tbl[i].lvl & ~m);
    endtask

    initial begin
        int a_b, b_b, c_b;
        logic [4:0] exp_p, exp_l, exp_r;
        logic       rep;

        rst    = 1'b1;
        button = 5'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_now", {level, press, release_pulse}, 15'b0);
        button = 5'b11111;
        repeat (6) @(posedge clk);
        #1;
        check("reset_held", {level, press, release_pulse}, 15'b0);
        @(negedge clk);
        button = 5'b0;
        rst    = 1'b1;
        repeat (3) step(5'b0);
        check("post_reset_idle", {level, press, release_pulse}, 15'b0);

        // Clean press/release on ch0, bounce rejection on ch1, simultaneous press.
        a_b = n_vec;
        seg(5'b00001, 20);
        seg(5'b00000, 10);
        b_b = n_vec;
        seg(5'b00010, 3);
        seg(5'b00000, 2);
        seg(5'b00010, 2);
        seg(5'b00000, 2);
        seg(5'b00010, 9);
        seg(5'b00000, 3);
        seg(5'b00010, 4);
        seg(5'b00000, 8);
        c_b = n_vec;
        seg(5'b10101, 10);
        seg(5'b00000, 10);

        mark(a_b + 5, 5'b00001, 5'b0);
        lvl_set(a_b + 5, 5'b00001, 1'b1);
        mark(a_b + 25, 5'b0, 5'b00001);
        lvl_set(a_b + 25, 5'b00001, 1'b0);
        mark(b_b + 14, 5'b00010, 5'b0);
        lvl_set(b_b + 14, 5'b00010, 1'b1);
        mark(b_b + 30, 5'b0, 5'b00010);
        lvl_set(b_b + 30, 5'b00010, 1'b0);
        mark(c_b + 5, 5'b10101, 5'b0);
        lvl_set(c_b + 5, 5'b10101, 1'b1);
        mark(c_b + 15, 5'b0, 5'b10101);
        lvl_set(c_b + 15, 5'b10101, 1'b0);
`ifdef AUTOREPEAT_EN
        mark(a_b + 15, 5'b00001, 5'b0);
        mark(a_b + 20, 5'b00001, 5'b0);
        mark(b_b + 24, 5'b00010, 5'b0);
        mark(b_b + 29, 5'b00010, 5'b0);
`endif

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].btn);
            check($sformatf("vec%0d", i), {level, press, release_pulse},
                  {tbl[i].lvl, tbl[i].prs, tbl[i].rel});
        end

        // Async reset during the third cycle of a press window on ch3, ch0 already held.
        for (int k = 1; k <= 8; k++) step(5'b00001);
        check("pre_reset_level", {level, press, release_pulse}, {5'b00001, 10'b0});
        for (int k = 1; k <= 5; k++) step(5'b01001);
        #2 rst = 1'b0;
        #1;
        check("async_reset_now", {level, press, release_pulse}, 15'b0);
        repeat (3) @(posedge clk);
        #1;
        check("async_reset_held", {level, press, release_pulse}, 15'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_p = (k == 6) ? 5'b01001 : 5'b0;
            exp_l = (k >= 6) ? 5'b01001 : 5'b0;
            check($sformatf("rearm_k%0d", k), {level, press, release_pulse},
                  {exp_l, exp_p, 5'b0});
        end
        for (int k = 1; k <= 6; k++) begin
            step(5'b0);
            exp_r = (k == 6) ? 5'b01001 : 5'b0;
            exp_l = (k == 6) ? 5'b0 : 5'b01001;
            check($sformatf("rearm_rel_k%0d", k), {level, press, release_pulse},
                  {exp_l, 5'b0, exp_r});
        end
        repeat (3) step(5'b0);

        // Long hold on ch2: press at +6, repeats only when auto-repeat is built in.
        for (int k = 1; k <= 40; k++) begin
            step(5'b00100);
            rep = 1'b0;
`ifdef AUTOREPEAT_EN
            rep = (k == 16 || k == 21 || k == 26 || k == 31 || k == 36);
`endif
            exp_p = (k == 6 || rep) ? 5'b00100 : 5'b0;
            exp_l = (k >= 6) ? 5'b00100 : 5'b0;
            check($sformatf("hold_k%0d", k), {level, press, release_pulse},
                  {exp_l, exp_p, 5'b0});
        end
        for (int k = 1; k <= 8; k++) begin
            step(5'b0);
            exp_r = (k == 6) ? 5'b00100 : 5'b0;
            exp_l = (k >= 6) ? 5'b0 : 5'b00100;
            check($sformatf("hold_rel_k%0d", k), {level, 5'b0, release_pulse},
                  {exp_l, 5'b0, exp_r});
            if (k == 6)
                check("hold_rel_no_press", {10'b0, press}, 15'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
